// File: rtl/fifo_pkg.sv
// Shared definitions for the parametrised FIFO: controller states, count width helper
// and default almost-flag thresholds.
package fifo_pkg;

    typedef enum logic {
        ST_IDLE  = 1'b0,
        ST_FLUSH = 1'b1
    } fifo_state_e;

    localparam int FIFO_AE_DEFAULT = 2;
    // almost_full default sits this many entries below DEPTH
    localparam int FIFO_AF_MARGIN  = 2;

    // Occupancy must represent 0..DEPTH inclusive, hence one extra bit.
    function automatic int fifo_cnt_width(input int depth_log2);
        return depth_log2 + 1;
    endfunction

endpackage

// File: rtl/fifo_mem_dp.sv
// WIDTH x 2**DEPTH_LOG2 register array: synchronous write, asynchronous read for FWFT.
// Write lands on the clock edge; read is combinational, no backpressure.
module fifo_mem_dp #(
    parameter int WIDTH      = 32,
    parameter int DEPTH_LOG2 = 4
) (
    input  logic                  clock,
    input  logic                  we_i,
    input  logic [DEPTH_LOG2-1:0] waddr_i,
    input  logic [WIDTH-1:0]      wdata_i,
    input  logic [DEPTH_LOG2-1:0] raddr_i,
    output logic [WIDTH-1:0]      rdata_o
);

    localparam int DEPTH = 2 ** DEPTH_LOG2;

    logic [WIDTH-1:0] mem_q [DEPTH];

    always_ff @(posedge clock) begin
        if (we_i) begin
            mem_q[waddr_i] <= wdata_i;
        end
    end

    assign rdata_o = mem_q[raddr_i];

endmodule

// File: rtl/fifo_ctrl_param.sv
// ce-gated synchronous FWFT FIFO with count, almost flags, sticky errors and a flush FSM.
// Flags/count settle one cycle after an accepted op; full/flush reject pushes and raise o_overflow.
module fifo_ctrl_param
    import fifo_pkg::*;
#(
    parameter int WIDTH      = 32,
    parameter int DEPTH_LOG2 = 4,
    parameter int AF_LEVEL   = (2 ** DEPTH_LOG2) - FIFO_AF_MARGIN,
    parameter int AE_LEVEL   = FIFO_AE_DEFAULT
) (
    input  logic                  clock,
    input  logic                  reset_n,
    input  logic                  ce,
    input  logic                  i_push,
    input  logic [WIDTH-1:0]      i_push_data,
    input  logic                  i_pop,
    output logic [WIDTH-1:0]      o_pop_data,
    output logic                  o_full,
    output logic                  o_empty,
    output logic [DEPTH_LOG2:0]   o_count,
    output logic                  o_almost_full,
    output logic                  o_almost_empty,
    output logic                  o_overflow,
    output logic                  o_underflow,
    input  logic                  i_flush_req,
    output logic                  o_flush_busy
);

    localparam int CW    = fifo_cnt_width(DEPTH_LOG2);
    localparam int DEPTH = 2 ** DEPTH_LOG2;

    localparam logic [CW-1:0]         DEPTH_C = CW'(DEPTH);
    localparam logic [CW-1:0]         AF_C    = CW'(AF_LEVEL);
    localparam logic [CW-1:0]         AE_C    = CW'(AE_LEVEL);
    localparam logic [CW-1:0]         CNT_ONE = CW'(1);
    localparam logic [DEPTH_LOG2-1:0] PTR_ONE = DEPTH_LOG2'(1);

    fifo_state_e           state_q, state_d;
    logic [DEPTH_LOG2-1:0] wr_ptr_q, wr_ptr_d;
    logic [DEPTH_LOG2-1:0] rd_ptr_q, rd_ptr_d;
    logic [CW-1:0]         count_q, count_d;
    logic                  ovf_q, ovf_d;
    logic                  unf_q, unf_d;

    logic                  ops_open;
    logic                  push_acc;
    logic                  pop_acc;
    logic [WIDTH-1:0]      rd_data;

    // A flush request claims the cycle, so push/pop alongside it count as rejected.
    assign ops_open = ce && (state_q == ST_IDLE) && !i_flush_req;
    assign pop_acc  = ops_open && i_pop && (count_q != '0);
    assign push_acc = ops_open && i_push && ((count_q != DEPTH_C) || pop_acc);

    always_comb begin
        state_d  = state_q;
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        ovf_d    = ovf_q | (ce && i_push && !push_acc);
        unf_d    = unf_q | (ce && i_pop && !pop_acc);

        if (ce) begin
            case (state_q)
                ST_IDLE: begin
                    if (i_flush_req) begin
                        state_d = ST_FLUSH;
                    end
                    if (push_acc) begin
                        wr_ptr_d = wr_ptr_q + PTR_ONE;
                    end
                    if (pop_acc) begin
                        rd_ptr_d = rd_ptr_q + PTR_ONE;
                    end
                    if (push_acc && !pop_acc) begin
                        count_d = count_q + CNT_ONE;
                    end else if (pop_acc && !push_acc) begin
                        count_d = count_q - CNT_ONE;
                    end
                end
                ST_FLUSH: begin
                    if (count_q != '0) begin
                        rd_ptr_d = rd_ptr_q + PTR_ONE;
                        count_d  = count_q - CNT_ONE;
                    end
                    // Leave on the cycle that drains the last entry (or at once if already empty).
                    if (count_q <= CNT_ONE) begin
                        state_d = ST_IDLE;
                    end
                end
                default: state_d = ST_IDLE;
            endcase
        end
    end

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            state_q  <= ST_IDLE;
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
            ovf_q    <= 1'b0;
            unf_q    <= 1'b0;
        end else begin
            state_q  <= state_d;
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
            ovf_q    <= ovf_d;
            unf_q    <= unf_d;
        end
    end

    fifo_mem_dp #(
        .WIDTH      (WIDTH),
        .DEPTH_LOG2 (DEPTH_LOG2)
    ) u_mem (
        .clock   (clock),
        .we_i    (push_acc),
        .waddr_i (wr_ptr_q),
        .wdata_i (i_push_data),
        .raddr_i (rd_ptr_q),
        .rdata_o (rd_data)
    );

    // Memory is not reset, so mask the head while empty to present a clean zero.
    assign o_pop_data     = (count_q == '0) ? '0 : rd_data;
    assign o_full         = (count_q == DEPTH_C);
    assign o_empty        = (count_q == '0);
    assign o_count        = count_q;
    assign o_almost_full  = (count_q >= AF_C);
    assign o_almost_empty = (count_q <= AE_C);
    assign o_overflow     = ovf_q;
    assign o_underflow    = unf_q;
    assign o_flush_busy   = (state_q == ST_FLUSH);

endmodule

// File: tb/tb_fifo_ctrl_param.sv
// Bench for fifo_ctrl_param (WIDTH=8, DEPTH=4): queue-based reference model compared every
// cycle, directed scenarios with literal expectations, then randomized traffic.
module tb_fifo_ctrl_param;

    localparam int DEPTH = 4;

    logic       clock = 1'b0;
    logic       reset_n = 1'b0;
    logic       ce = 1'b0;
    logic       i_push = 1'b0;
    logic [7:0] i_push_data = 8'h00;
    logic       i_pop = 1'b0;
    logic       i_flush_req = 1'b0;
    logic [7:0] o_pop_data;
    logic       o_full, o_empty, o_almost_full, o_almost_empty;
    logic       o_overflow, o_underflow, o_flush_busy;
    logic [2:0] o_count;

    fifo_ctrl_param #(
        .WIDTH      (8),
        .DEPTH_LOG2 (2),
        .AF_LEVEL   (2),
        .AE_LEVEL   (2)
    ) dut (
        .clock          (clock),
        .reset_n        (reset_n),
        .ce             (ce),
        .i_push         (i_push),
        .i_push_data    (i_push_data),
        .i_pop          (i_pop),
        .o_pop_data     (o_pop_data),
        .o_full         (o_full),
        .o_empty        (o_empty),
        .o_count        (o_count),
        .o_almost_full  (o_almost_full),
        .o_almost_empty (o_almost_empty),
        .o_overflow     (o_overflow),
        .o_underflow    (o_underflow),
        .i_flush_req    (i_flush_req),
        .o_flush_busy   (o_flush_busy)
    );

    always #5 clock = ~clock;

    int n_tests = 0;
    int n_fail  = 0;
    bit check_en = 1'b0;

    // Reference model: contents as a queue, sticky flags, and whether a flush is running.
    logic [7:0] m_q[$];
    bit         m_ovf  = 1'b0;
    bit         m_unf  = 1'b0;
    bit         m_busy = 1'b0;

    function automatic void chk(string name, int act, int exp);
        n_tests++;
        if (act != exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h at t=%0t", name, act, exp, $time);
        end
    endfunction

    function automatic void model_step(logic c, logic p, logic [7:0] d, logic q, logic f);
        bit pop_ok;
        bit push_ok;
        if (!c) return;
        if (m_busy) begin
            if (p) m_ovf = 1'b1;
            if (q) m_unf = 1'b1;
            if (m_q.size() > 0) void'(m_q.pop_front());
            if (m_q.size() == 0) m_busy = 1'b0;
        end else if (f) begin
            m_busy = 1'b1;
            if (p) m_ovf = 1'b1;
            if (q) m_unf = 1'b1;
        end else begin
            pop_ok  = q && (m_q.size() > 0);
            push_ok = p && ((m_q.size() < DEPTH) || pop_ok);
            if (q && !pop_ok)  m_unf = 1'b1;
            if (p && !push_ok) m_ovf = 1'b1;
            if (pop_ok)  void'(m_q.pop_front());
            if (push_ok) m_q.push_back(d);
        end
    endfunction

    // Drive one cycle of inputs, advance the model at the sampling edge, return just after it.
    task automatic step(input logic c, input logic p, input logic [7:0] d,
                        input logic q, input logic f);
        ce = c; i_push = p; i_push_data = d; i_pop = q; i_flush_req = f;
        @(posedge clock);
        model_step(c, p, d, q, f);
        #1;
        ce = 1'b0; i_push = 1'b0; i_pop = 1'b0; i_flush_req = 1'b0;
    endtask

    task automatic do_reset();
        check_en = 1'b0;
        ce = 1'b0; i_push = 1'b0; i_pop = 1'b0; i_flush_req = 1'b0;
        reset_n = 1'b0;
        m_q.delete();
        m_ovf = 1'b0; m_unf = 1'b0; m_busy = 1'b0;
        repeat (2) @(posedge clock);
        #1;
        reset_n = 1'b1;
        check_en = 1'b1;
    endtask

    // Every-cycle comparison of all outputs against the model.
    always @(negedge clock) begin
        if (check_en) begin
            chk("count",        int'(o_count),        m_q.size());
            chk("empty",        int'(o_empty),        int'(m_q.size() == 0));
            chk("full",         int'(o_full),         int'(m_q.size() == DEPTH));
            chk("almost_full",  int'(o_almost_full),  int'(m_q.size() >= 2));
            chk("almost_empty", int'(o_almost_empty), int'(m_q.size() <= 2));
            chk("overflow",     int'(o_overflow),     int'(m_ovf));
            chk("underflow",    int'(o_underflow),    int'(m_unf));
            chk("flush_busy",   int'(o_flush_busy),   int'(m_busy));
            if (m_q.size() > 0) chk("pop_data", int'(o_pop_data), int'(m_q[0]));
        end
    end

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation time limit reached, got timeout, expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [7:0] exp_data [4];
        int n;
        int pushed;
        int popped;
        logic pp;
        logic ps;

        // Reset state.
        do_reset();
        chk("rst_empty", int'(o_empty), 1);
        chk("rst_full", int'(o_full), 0);
        chk("rst_count", int'(o_count), 0);
        chk("rst_ae", int'(o_almost_empty), 1);
        chk("rst_af", int'(o_almost_full), 0);
        chk("rst_flags", int'({o_overflow, o_underflow, o_flush_busy}), 0);
        chk("rst_data", int'(o_pop_data), 0);

        // Fill to full, drain in order.
        exp_data[0] = 8'h11; exp_data[1] = 8'h22; exp_data[2] = 8'h33; exp_data[3] = 8'h44;
        for (int i = 0; i < 4; i++) step(1'b1, 1'b1, exp_data[i], 1'b0, 1'b0);
        chk("fill_full", int'(o_full), 1);
        chk("fill_count", int'(o_count), 4);
        chk("fill_af", int'(o_almost_full), 1);
        chk("fill_ae", int'(o_almost_empty), 0);
        for (int i = 0; i < 4; i++) begin
            chk("drain_data", int'(o_pop_data), int'(exp_data[i]));
            step(1'b1, 1'b0, 8'h00, 1'b1, 1'b0);
        end
        chk("drain_empty", int'(o_empty), 1);

        // Push while full, then simultaneous push/pop while full.
        do_reset();
        for (int i = 0; i < 4; i++) step(1'b1, 1'b1, exp_data[i], 1'b0, 1'b0);
        step(1'b1, 1'b1, 8'h55, 1'b0, 1'b0);
        chk("ovf_set", int'(o_overflow), 1);
        chk("ovf_count", int'(o_count), 4);
        step(1'b1, 1'b1, 8'h66, 1'b1, 1'b0);
        chk("fullpp_count", int'(o_count), 4);
        chk("fullpp_head", int'(o_pop_data), 8'h22);
        for (int i = 0; i < 3; i++) step(1'b1, 1'b0, 8'h00, 1'b1, 1'b0);
        chk("fullpp_tail", int'(o_pop_data), 8'h66);

        // Simultaneous push/pop on an empty FIFO.
        do_reset();
        step(1'b1, 1'b1, 8'hA5, 1'b1, 1'b0);
        chk("emptypp_unf", int'(o_underflow), 1);
        chk("emptypp_ovf", int'(o_overflow), 0);
        chk("emptypp_count", int'(o_count), 1);
        chk("emptypp_data", int'(o_pop_data), 8'hA5);

        // Flush of 3 entries with a push attempted while busy.
        do_reset();
        for (int i = 0; i < 3; i++) step(1'b1, 1'b1, exp_data[i], 1'b0, 1'b0);
        step(1'b1, 1'b0, 8'h00, 1'b0, 1'b1);
        n = 0;
        while (o_flush_busy && n < 20) begin
            step(1'b1, (n == 0), 8'h77, 1'b0, 1'b0);
            n++;
        end
        chk("flush3_cycles", n, 3);
        chk("flush3_empty", int'(o_empty), 1);
        chk("flush3_ovf", int'(o_overflow), 1);

        // ce=0 freezes everything, then flush of an empty FIFO.
        do_reset();
        step(1'b1, 1'b1, 8'hAA, 1'b0, 1'b0);
        step(1'b1, 1'b1, 8'hBB, 1'b0, 1'b0);
        for (int i = 0; i < 5; i++) begin
            step(1'b0, 1'b1, 8'hCC, 1'b1, 1'b1);
            chk("ce0_count", int'(o_count), 2);
            chk("ce0_data", int'(o_pop_data), 8'hAA);
            chk("ce0_flags", int'({o_overflow, o_underflow, o_flush_busy}), 0);
        end
        step(1'b1, 1'b0, 8'h00, 1'b1, 1'b0);
        step(1'b1, 1'b0, 8'h00, 1'b1, 1'b0);
        step(1'b1, 1'b0, 8'h00, 1'b0, 1'b1);
        n = 0;
        while (o_flush_busy && n < 20) begin
            step(1'b1, 1'b0, 8'h00, 1'b0, 1'b0);
            n++;
        end
        chk("flush0_cycles", n, 1);
        chk("flush0_flags", int'({o_overflow, o_underflow}), 0);

        // Wrap-around: 20 words with interleaved pops, order checked against push sequence.
        do_reset();
        pushed = 0; popped = 0; n = 0;
        while (popped < 20 && n < 200) begin
            pp = !o_empty && ((n % 3 != 0) || pushed == 20);
            ps = (pushed < 20) && (!o_full || pp);
            if (pp) begin
                chk("wrap_order", int'(o_pop_data), 8'h30 + popped);
                popped++;
            end
            step(1'b1, ps, 8'(8'h30 + pushed), pp, 1'b0);
            if (ps) pushed++;
            n++;
        end
        chk("wrap_popped", popped, 20);
        chk("wrap_errs", int'({o_overflow, o_underflow}), 0);

        // Reset asserted mid-flush acts immediately.
        do_reset();
        for (int i = 0; i < 4; i++) step(1'b1, 1'b1, exp_data[i], 1'b0, 1'b0);
        step(1'b1, 1'b0, 8'h00, 1'b0, 1'b1);
        step(1'b1, 1'b0, 8'h00, 1'b0, 1'b0);
        check_en = 1'b0;
        #1;
        reset_n = 1'b0;
        #1;
        chk("midrst_busy", int'(o_flush_busy), 0);
        chk("midrst_empty", int'(o_empty), 1);
        chk("midrst_count", int'(o_count), 0);
        do_reset();

        // Randomized traffic against the model.
        for (int i = 0; i < 3000; i++) begin
            step(($urandom_range(0, 9) != 0), $urandom_range(0, 1) == 1,
                 8'($urandom_range(0, 255)), $urandom_range(0, 1) == 1,
                 $urandom_range(0, 39) == 0);
        end

        check_en = 1'b0;
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/fifo_ctrl_param.md
Name: fifo_ctrl_param

Overview:
- Parametrised, ce-gated synchronous FIFO; next generation of the FIFOTest block. Adds configurable width/depth, occupancy count, programmable almost flags, sticky error flags and a multi-cycle flush method.
- Flush uses the same i_*_req / o_*_busy handshake as the generated run method, so existing benches drive it unchanged.
- Sits between generated compute modules as an inter-stage buffer.

Parameters:
- WIDTH, 32, data word width in bits.
- DEPTH_LOG2, 4, log2 of entry count; DEPTH = 2**DEPTH_LOG2.
- AF_LEVEL, DEPTH-2, o_almost_full asserts when count >= AF_LEVEL.
- AE_LEVEL, 2, o_almost_empty asserts when count <= AE_LEVEL.

Ports:
- clock  in  1  system clock, rising edge.
- reset_n  in  1  asynchronous, active-low reset.
- ce  in  1  clock enable; when 0, all state holds.
- i_push  in  1  write request.
- i_push_data  in  WIDTH  write data.
- i_pop  in  1  read request; consumes the head entry.
- o_pop_data  out  WIDTH  head entry, first-word-fall-through; valid when o_empty=0.
- o_full  out  1  count == DEPTH.
- o_empty  out  1  count == 0.
- o_count  out  DEPTH_LOG2+1  occupancy, 0..DEPTH.
- o_almost_full  out  1  count >= AF_LEVEL.
- o_almost_empty  out  1  count <= AE_LEVEL.
- o_overflow  out  1  sticky; set by a rejected push.
- o_underflow  out  1  sticky; set by a rejected pop.
- i_flush_req  in  1  flush request pulse.
- o_flush_busy  out  1  high while a flush is in progress.

Behaviour:
- Reset (async, reset_n=0): pointers and count 0; o_empty=1, o_full=0, o_almost_empty=1, o_almost_full=0 (AF_LEVEL>0); o_overflow=0, o_underflow=0, o_flush_busy=0; FSM = IDLE; o_pop_data = 0. Memory contents are not reset.
- ce=0: no state changes. Outputs hold. Requests in that cycle are lost and no error flags are set.
- Push accepted when ce=1, FSM=IDLE and (count<DEPTH or an accepted pop occurs in the same cycle). Data is written at wr_ptr and wr_ptr increments mod DEPTH.
- Pop accepted when ce=1, FSM=IDLE and count>0. rd_ptr increments mod DEPTH.
- Flags update on the edge after the accepted operation; latency 1 cycle.
- Empty + push: o_pop_data shows the new word and o_empty=0 on the next cycle.
- Push and pop together, 0<count<DEPTH: count unchanged, both pointers advance.
- Push and pop together when full: both accepted, count stays DEPTH.
- Push and pop together when empty: push accepted, pop rejected, o_underflow set.
- Rejected push (full without a pop, or during FLUSH): o_overflow set; cleared only by reset.
- Rejected pop (empty, or during FLUSH): o_underflow set; cleared only by reset.
- Pointers are DEPTH_LOG2 bits and wrap naturally. Count is computed with DEPTH_LOG2+1 bits and never wraps.
- FSM has two states, IDLE and FLUSH.
  - IDLE -> FLUSH on i_flush_req=1 with ce=1. i_push and i_pop in that same cycle are ignored and treated as rejected.
  - In FLUSH, one entry is discarded per ce cycle (rd_ptr++, count--).
  - FLUSH -> IDLE in the cycle count reaches 0.
  - o_flush_busy = (state==FLUSH), registered, so it rises one cycle after the req edge.
  - Flushing a non-empty FIFO of N entries keeps busy high for N cycles. Flushing an empty FIFO keeps busy high for exactly 1 cycle.
  - i_flush_req while already in FLUSH is ignored.
- Reset mid-flush: returns to IDLE immediately, FIFO empty.

Decomposition:
- Shared package fifo_pkg holds: the FSM state enum (ST_IDLE, ST_FLUSH), a function computing the count width, and default AF/AE constants.
- One sub-module, fifo_mem_dp: a simple dual-port register array, WIDTH x DEPTH, synchronous write and asynchronous read, used for FWFT.
- The top holds pointers, count, flags and the FSM.

Test Plan:
- WIDTH=8, DEPTH_LOG2=2: reset, push 0x11,0x22,0x33,0x44 -> o_full=1, o_count=4; pop four times -> data 11,22,33,44 in order, then o_empty=1.
- Full FIFO, push 0x55 alone -> o_overflow=1, o_count stays 4; then push 0x66 with pop in the same cycle -> head 0x22, tail 0x66, count 4.
- Empty FIFO, push 0xA5 with pop in the same cycle -> o_underflow=1, o_count=1, o_pop_data=0xA5 next cycle.
- Fill 3 entries, pulse i_flush_req -> o_flush_busy high exactly 3 cycles, then o_empty=1; a push during busy -> o_overflow=1, count unaffected.
- Hold ce=0 for 5 cycles with push/pop/flush asserted -> count, flags and data unchanged; flush on an empty FIFO -> busy for 1 cycle.
- Push 20 words with interleaved pops (DEPTH=4) to exercise wrap-around -> output order matches input; o_almost_full/o_almost_empty track count against AF_LEVEL=2, AE_LEVEL=2.
